// File: rtl/proj_hasher_pipe.sv
// proj_hasher_pipe: pipelined multi-seed MurmurHash3-style k-mer signature generator
// Sits between the k-mer buffer and the min-signature tracker.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   seed_we, seed_idx, seed_wdata       seed bank write (honoured only while idle)
//   in_valid, in_ready, in_kmer, in_last   k-mer input handshake and last tag
//   out_valid, out_ready, out_sig, out_last   signature output handshake, lane i at [i*DATA_BITS +: DATA_BITS]
//   busy                                any pipeline register holds valid data
module proj_hasher_pipe #(
  parameter int KMER_LEN   = 16,
  parameter int BASE_BITS  = 2,
  parameter int DATA_BITS  = KMER_LEN * BASE_BITS,
  parameter int NUM_SEEDS  = 4,
  parameter int SEED_IDX_W = (NUM_SEEDS == 1) ? 1 : $clog2(NUM_SEEDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           seed_we,
  input  logic [SEED_IDX_W-1:0]          seed_idx,
  input  logic [DATA_BITS-1:0]           seed_wdata,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_BITS-1:0]           in_kmer,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_SEEDS*DATA_BITS-1:0] out_sig,
  output logic                           out_last,
  output logic                           busy
);
  localparam logic [DATA_BITS-1:0] C1 = DATA_BITS'(32'hcc9e2d51);
  localparam logic [DATA_BITS-1:0] C2 = DATA_BITS'(32'h1b873593);
  localparam logic [DATA_BITS-1:0] N  = DATA_BITS'(32'he6546b64);
  localparam logic [DATA_BITS-1:0] M  = DATA_BITS'(5);

  function automatic logic [DATA_BITS-1:0] rol(input logic [DATA_BITS-1:0] x, input int r);
    return (x << r) | (x >> (DATA_BITS - r));
  endfunction

  // The k-mer is registered on acceptance so that k1, k2 and the lane signatures
  // each get their own register, giving three cycles from accept to out_valid.
  logic                           v0_q, v1_q, v2_q, v3_q;
  logic                           l0_q, l1_q, l2_q, l3_q;
  logic [DATA_BITS-1:0]           kmer_q, k1_q, k2_q;
  logic [DATA_BITS-1:0]           k1_d, k2_d;
  logic [NUM_SEEDS*DATA_BITS-1:0] sig_q, sig_d;
  logic [DATA_BITS-1:0]           seed_q [NUM_SEEDS];
  logic                           adv, seed_wr;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign busy      = v0_q || v1_q || v2_q || v3_q;
  assign seed_wr   = seed_we && !busy;
  assign out_valid = v3_q;
  assign out_sig   = sig_q;
  assign out_last  = l3_q;
  assign k1_d      = kmer_q * C1;
  assign k2_d      = rol(k1_q, 15) * C2;

  // Seeds are sampled as a k-mer enters the last register; writes only happen
  // while the pipe is empty, so every in-flight k-mer sees a single seed set.
  for (genvar i = 0; i < NUM_SEEDS; i++) begin : g_lane
    assign sig_d[i*DATA_BITS +: DATA_BITS] = rol(seed_q[i] ^ k2_q, 13) * M + N;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {v0_q, v1_q, v2_q, v3_q} <= '0;
      {l0_q, l1_q, l2_q, l3_q} <= '0;
      kmer_q <= '0;
      k1_q   <= '0;
      k2_q   <= '0;
      sig_q  <= '0;
      for (int j = 0; j < NUM_SEEDS; j++) seed_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_SEEDS; j++)
        if (seed_wr && seed_idx == SEED_IDX_W'(j)) seed_q[j] <= seed_wdata;
      if (adv) begin
        v0_q <= in_valid;
        v1_q <= v0_q;
        v2_q <= v1_q;
        v3_q <= v2_q;
        if (in_valid) begin
          kmer_q <= in_kmer;
          l0_q   <= in_last;
        end
        if (v0_q) begin
          k1_q <= k1_d;
          l1_q <= l0_q;
        end
        if (v1_q) begin
          k2_q <= k2_d;
          l2_q <= l1_q;
        end
        if (v2_q) begin
          sig_q <= sig_d;
          l3_q  <= l2_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_proj_hasher_pipe.sv
// tb_proj_hasher_pipe: randomized scoreboard bench for proj_hasher_pipe
module tb_proj_hasher_pipe;
  logic         clk = 0;
  logic         rst = 1;
  logic         seed_we = 0;
  logic [1:0]   seed_idx = 0;
  logic [31:0]  seed_wdata = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [31:0]  in_kmer = 0;
  logic         in_last = 0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [127:0] out_sig;
  logic         out_last;
  logic         busy;

  proj_hasher_pipe dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_idx(seed_idx), .seed_wdata(seed_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_kmer(in_kmer), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] hash(input logic [31:0] kmer, input logic [31:0] seed);
    logic [31:0] k1, k2;
    k1 = kmer * 32'hcc9e2d51;
    k2 = rl(k1, 15) * 32'h1b873593;
    return rl(seed ^ k2, 13) * 32'd5 + 32'he6546b64;
  endfunction

  // Reference: every accepted k-mer is queued with its precomputed signatures and
  // the number of advancing edges it has seen; it is visible once that reaches 3.
  typedef struct {
    logic [127:0] sig;
    logic         last;
    int           pos;
  } item_t;
  item_t       q[$];
  logic [31:0] m_seed [4] = '{default: 0};
  bit          ev, adv;

  always begin
    @(negedge clk);
    if (!rst) begin
      ev = q.size() > 0 && q[0].pos >= 3;
      cmp("in_ready", 128'(in_ready), 128'(!ev || out_ready));
      cmp("out_valid", 128'(out_valid), 128'(ev));
      cmp("busy", 128'(busy), 128'(q.size() > 0));
      if (ev) begin
        cmp("out_sig", out_sig, q[0].sig);
        cmp("out_last", 128'(out_last), 128'(q[0].last));
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_seed = '{default: 0};
    end else begin
      ev  = q.size() > 0 && q[0].pos >= 3;
      adv = !ev || out_ready;
      if (seed_we && q.size() == 0) m_seed[seed_idx] = seed_wdata;
      if (adv) begin
        item_t it;
        if (ev) void'(q.pop_front());
        foreach (q[k]) if (q[k].pos < 3) q[k].pos++;
        if (in_valid) begin
          for (int l = 0; l < 4; l++) it.sig[l*32 +: 32] = hash(in_kmer, m_seed[l]);
          it.last = in_last;
          it.pos  = 0;
          q.push_back(it);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send0(input logic [127:0] exp, input string nm);
    in_valid = 1;
    in_kmer  = 0;
    in_last  = 0;
    step();
    in_valid = 0;
    step(2);
    cmp({nm, "_early"}, 128'(out_valid), 128'(0));
    step();
    cmp({nm, "_valid"}, 128'(out_valid), 128'(1));
    cmp(nm, out_sig, exp);
    step();
  endtask

  logic [127:0] held;

  initial begin
    cmp("model_zero", 128'(hash(0, 0)), 128'(32'he6546b64));
    cmp("model_seed1", 128'(hash(0, 1)), 128'(32'he6550b64));
    cmp("model_wrap", 128'(hash(0, 32'h80000000)), 128'(32'he654bb64));
    step(2);
    cmp("rst_valid", 128'(out_valid), 128'(0));
    cmp("rst_busy", 128'(busy), 128'(0));
    cmp("rst_ready", 128'(in_ready), 128'(1));
    cmp("rst_sig", out_sig, 128'(0));
    cmp("rst_last", 128'(out_last), 128'(0));
    rst = 0;
    step();
    send0({4{32'he6546b64}}, "zero_seeds");

    seed_we = 1; seed_idx = 1; seed_wdata = 32'h00000001;
    step();
    seed_idx = 2; seed_wdata = 32'h80000000;
    step();
    seed_we = 0;
    send0({32'he6546b64, 32'he654bb64, 32'he6550b64, 32'he6546b64}, "seeded");

    seed_we = 1; seed_idx = 3; seed_wdata = 32'h00000001;
    in_valid = 1; in_kmer = 0; in_last = 0;
    step();
    seed_we = 0; in_valid = 0;
    step(3);
    cmp("simul_sig", out_sig, {32'he6550b64, 32'he654bb64, 32'he6550b64, 32'he6546b64});
    step();

    in_valid = 1; in_kmer = 32'h12345678;
    step();
    in_valid = 0;
    seed_we = 1; seed_idx = 0; seed_wdata = 32'hffffffff;
    step();
    seed_we = 0;
    step(4);
    send0({32'he6550b64, 32'he654bb64, 32'he6550b64, 32'he6546b64}, "busy_write");
    seed_we = 1; seed_idx = 0; seed_wdata = 32'h00000001;
    step();
    seed_we = 0;
    send0({32'he6550b64, 32'he654bb64, 32'he6550b64, 32'he6550b64}, "idle_write");

    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_kmer = $urandom; in_last = (i == 7);
      step();
    end
    in_valid = 0; in_last = 0;
    step(6);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_kmer = $urandom; in_last = i[0];
      step();
    end
    out_ready = 0;
    held = out_sig;
    for (int i = 0; i < 5; i++) begin
      in_kmer = $urandom;
      step();
    end
    cmp("stall_hold", out_sig, held);
    cmp("stall_ready", 128'(in_ready), 128'(0));
    out_ready = 1; in_valid = 0;
    step(6);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_kmer = $urandom;
      step();
    end
    in_valid = 0; rst = 1;
    step();
    cmp("midrst_valid", 128'(out_valid), 128'(0));
    cmp("midrst_busy", 128'(busy), 128'(0));
    rst = 0;
    step(5);

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      seed_we    = ($urandom_range(0, 15) == 0);
      seed_idx   = 2'($urandom_range(0, 3));
      seed_wdata = $urandom;
      in_kmer    = $urandom;
      in_last    = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0; in_valid = 0; out_ready = 1; seed_we = 0;
    step(8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
